fpu_sequencer: RTL and testbench

Command-side initiator for the floating-point unit's level `start`/`done` handshake. Buffers operand/opcode commands from an upstream valid/ready port and issues them one at a time to `fpu`, holding operands stable while the unit works. Returns each result, or a timeout indication, on a downstream valid/ready port. Sits between the control datapath and the `fpu` instance, replacing hand-driven start pulses.

---
 rtl/fpu_sequencer.sv | 137 +++++++++++++
 tb/tb_fpu_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sequencer.sv
// Command sequencer for the FPU start/done handshake: queues operand commands,
// runs them one at a time with a watchdog, and returns results downstream.
module fpu_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [1:0]  cmd_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_r,
    output logic        rsp_timeout,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_op,
    output logic        fpu_start,
    input  logic        fpu_done,
    input  logic [31:0] fpu_r,
    output logic        busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP,
        GAP
    } state_t;

    state_t             state;
    logic [65:0]        fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               push;
    logic               pop;
    logic               fifo_empty;

    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count != CNT_W'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state == IDLE) & ~fifo_empty;
    assign busy       = (state != IDLE) | ~fifo_empty;

    // Command storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            fpu_a       <= '0;
            fpu_b       <= '0;
            fpu_op      <= '0;
            fpu_start   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_r       <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        {fpu_op, fpu_a, fpu_b} <= fifo_mem[rd_ptr];
                        tmo_cnt   <= '0;
                        fpu_start <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // A done seen on the final watchdog cycle still counts as a real result.
                    if (fpu_done) begin
                        rsp_r       <= fpu_r;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        fpu_start   <= 1'b0;
                        state       <= RESP;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        rsp_r       <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        fpu_start   <= 1'b0;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    // Wait for the unit to drop done so the next start is seen as fresh.
                    if (!fpu_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench for fpu_sequencer with a behavioural FPU of per-command latency.
module tb_fpu_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [1:0]  cmd_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_r;
    logic        rsp_timeout;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [1:0]  fpu_op;
    logic        fpu_start;
    logic        fpu_done;
    logic [31:0] fpu_r;
    logic        busy;

    typedef struct {
        logic [31:0] r;
        logic        to;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   checks = 0;
    int   failures = 0;
    int   next_lat = 10;
    int   rsp_cnt = 0;
    int   accepted = 0;

    always #5 clk = ~clk;

    fpu_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r(rsp_r), .rsp_timeout(rsp_timeout),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
        .fpu_start(fpu_start), .fpu_done(fpu_done), .fpu_r(fpu_r),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Known IEEE pairs give true results; other operands get an arbitrary but
    // deterministic word so ordering and pass-through are still observable.
    function automatic logic [31:0] fpu_calc(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
        if (a == 32'h3FA00000 && b == 32'h3FC00000 && op == 2'b00) return 32'h40300000;
        if (a == 32'h40200000 && b == 32'h40980000 && op == 2'b10) return 32'h413E0000;
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endfunction

    // Behavioural FPU: done is sampled by the sequencer after exactly lat cycles
    // of start high; lat 0 means the unit never finishes.
    logic model_active;
    int   model_cnt;
    int   model_lat;
    always @(posedge clk or negedge reset) begin : fpu_model
        int l;
        if (!reset) begin
            model_active <= 1'b0;
            model_cnt    <= 0;
            model_lat    <= 0;
            fpu_done     <= 1'b0;
            fpu_r        <= '0;
        end else if (!fpu_start) begin
            model_active <= 1'b0;
            model_cnt    <= 0;
            fpu_done     <= 1'b0;
        end else begin
            if (model_active) l = model_lat;
            else l = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            model_active <= 1'b1;
            model_lat    <= l;
            model_cnt    <= model_cnt + 1;
            if (l != 0 && model_cnt + 1 == l - 1) begin
                fpu_done <= 1'b1;
                fpu_r    <= fpu_calc(fpu_a, fpu_b, fpu_op);
            end
        end
    end

    logic        prev_start;
    logic        prev_rsp;
    logic        seen_op;
    logic        unstable;
    logic [65:0] prev_ops;
    int          hi_run;
    int          last_hi;
    int          lo_run;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            prev_start = 1'b0;
            prev_rsp   = 1'b0;
            seen_op    = 1'b0;
            unstable   = 1'b0;
            hi_run     = 0;
            lo_run     = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                e.r   = (next_lat == 0) ? 32'd0 : fpu_calc(cmd_a, cmd_b, cmd_op);
                e.to  = (next_lat == 0);
                e.len = (next_lat == 0) ? TIMEOUT : next_lat;
                exp_q.push_back(e);
                lat_q.push_back(next_lat);
                accepted++;
            end
            if (fpu_start) begin
                if (!prev_start) begin
                    if (seen_op) chk("start_low_gap", lo_run >= 2, 1);
                    seen_op  = 1'b1;
                    unstable = 1'b0;
                    hi_run   = 0;
                end else if ({fpu_a, fpu_b, fpu_op} != prev_ops) begin
                    unstable = 1'b1;
                end
                hi_run++;
                lo_run = 0;
            end else begin
                if (prev_start) last_hi = hi_run;
                lo_run++;
            end
            if (rsp_valid && !prev_rsp) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_r", rsp_r, e.r);
                    chk("rsp_timeout", rsp_timeout, e.to);
                    chk("start_high_len", last_hi, e.len);
                    chk("start_low_at_rsp", fpu_start, 0);
                    chk("ops_stable", unstable, 0);
                end
            end
            prev_start = fpu_start;
            prev_rsp   = rsp_valid;
            prev_ops   = {fpu_a, fpu_b, fpu_op};
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input int lat);
        int n;
        n = 0;
        next_lat  = lat;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (!cmd_ready) chk("send_accept", 0, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || rsp_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_r"}, rsp_r, 0);
        chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
        chk({tag, "_fpu_a"}, fpu_a, 0);
        chk({tag, "_fpu_b"}, fpu_b, 0);
        chk({tag, "_fpu_op"}, fpu_op, 0);
        chk({tag, "_fpu_start"}, fpu_start, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int rsp0;
        #1;
        check_reset_vals("por");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        rsp_ready = 1'b1;

        // Add and multiply, latency 50 and 7
        send(32'h3FA00000, 32'h3FC00000, 2'b00, 50);
        wait_idle(500);
        send(32'h40200000, 32'h40980000, 2'b10, 7);
        wait_idle(500);

        // Fill under backpressure: 4 queued plus 1 in flight
        rsp_ready = 1'b0;
        acc0 = accepted;
        rsp0 = rsp_cnt;
        for (int i = 0; i < 6; i++) begin
            next_lat  = 10 + i;
            cmd_a     = $urandom;
            cmd_b     = $urandom;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("fill_accepted", accepted - acc0, 5);
        chk("fill_ready_low", cmd_ready, 0);
        repeat (30) @(posedge clk);
        #1 chk("fill_held_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        wait_idle(1000);
        chk("fill_rsp_count", rsp_cnt - rsp0, 5);

        // Timeout followed by a normal command
        send(32'h11111111, 32'h22222222, 2'b01, 0);
        send(32'h33333333, 32'h44444444, 2'b11, 20);
        wait_idle(5000);

        // Done arrives on the last watchdog cycle
        send(32'h3FA00000, 32'h3FC00000, 2'b00, TIMEOUT);
        wait_idle(5000);

        // Asynchronous reset while running with two commands queued
        send(32'h55555555, 32'h66666666, 2'b00, 100);
        send(32'h77777777, 32'h88888888, 2'b10, 100);
        send(32'h99999999, 32'hAAAAAAAA, 2'b01, 100);
        repeat (10) @(posedge clk);
        #2 chk("run_before_reset", fpu_start, 1);
        reset = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", cmd_ready, 1);
        rsp0 = rsp_cnt;
        repeat (200) @(posedge clk);
        #1 chk("no_rsp_after_reset", rsp_cnt, rsp0);

        send(32'h40200000, 32'h40980000, 2'b10, 30);
        wait_idle(500);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
